// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : uart_pkg                                                         |
// | Shared UART receive state encoding and default configuration constants.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        PARITY = 3'd5
    } rx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   N_DEF         = 10;
    localparam int   DATA_BITS_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_bit_timer                                                   |
// | Down-counting bit-period timer; tick is high for one cycle per N clocks.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(N) + 1;
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(N / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(N - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Reload on wrap keeps successive ticks exactly N cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= c_full;
        end else if (load_half) begin
            r_cnt <= c_half;
        end else if (load_full || r_cnt == '0) begin
            r_cnt <= c_full;
        end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign tick = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_unit                                                     |
// | 8N1 UART receiver with mid-bit sampling and valid/ack byte delivery.       |
// | Define UART_RX_PARITY_EN to add an even-parity bit and parity_err output.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ack,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int                 c_bit_w    = $clog2(DATA_BITS + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_load_half;
    logic                 w_load_full;
    logic                 w_shift_en;
    logic                 w_stop_good;
    logic                 w_stop_bad;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_deliver;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 w_par_check;
    logic                 w_par_bad_now;
    logic                 r_par_bad;
    logic                 r_parity_err;
`endif

    assign w_rx_s = r_sync2;

    uart_bit_timer #(
        .N (N)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .load_half (w_load_half),
        .load_full (w_load_full),
        .tick      (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_check = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next      = START;
                    w_load_half = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_next = IDLE;
                    end else begin
                        w_next      = DATA;
                        w_load_full = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_par_check = 1'b1;
                    w_next      = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_stop_good = 1'b1;
                        w_next      = IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the payload.
    assign w_par_bad_now = w_rx_s ^ (^r_shift);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= UART_IDLE_LVL;
            r_sync2     <= UART_IDLE_LVL;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_deliver   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_frame_err <= w_stop_bad;
            if (w_load_half) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
            end
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_par_check & w_par_bad_now;
            if (w_load_half) begin
                r_par_bad <= 1'b0;
            end else if (w_par_check) begin
                r_par_bad <= w_par_bad_now;
            end
            r_deliver <= w_stop_good & ~r_par_bad;
`else
            r_deliver <= w_stop_good;
`endif
        end
    end

    // Handshake: an ack coinciding with a delivery retires the old byte in favour of the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || ack) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_unit                                                  |
// | Self-checking bench for uart_rx_unit (vector table, corner cases, random). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_uart_rx_unit;

    localparam int N  = 10;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int c_par_n = N;
`else
    localparam int c_par_n = 0;
`endif
    localparam int c_lat = 2 + N / 2 + (DB + 1) * N + 1 + c_par_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pe_cnt   = 0;
    int fe0, ov0, pe0, lat, cyc;
    bit seen;
    bit par_flip = 1'b0;

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        bit         ack_after;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
        int         exp_ov;
    } vec_t;
    vec_t vecs[7];

    // Frame-level reference model state for the random phase
    bit         mv;
    logic [7:0] md;
    logic [7:0] rb;
    bit         r_stop_ok;
    int         e_fe, e_ov, e_pe;

    always #5 clk = ~clk;

    uart_rx_unit #(
        .N         (N),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ack        (ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pe_cnt++;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All drive tasks enter and leave 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] b);
        drive_bit(1'b0, N);
        for (int i = 0; i < DB; i++) drive_bit(b[i], N);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip, N);
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        send_body(b);
        if (stop_ok) begin
            drive_bit(1'b1, N);
        end else begin
            drive_bit(1'b0, N);
            drive_bit(1'b1, N);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (busy === lvl) ok = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        //             b      stop ack  valid data   fe ov
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 1};
        vecs[2] = '{8'h0F, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 0};
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 0, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 0, 0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single frame: latency counted from the first edge that samples the start bit
        lat = -1;
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (lat < 0 && cyc < 300) begin
                    @(negedge clk);
                    if (valid === 1'b1) lat = cyc - 1;
                    cyc++;
                end
            end
        join
        chk("t1_latency", lat, c_lat);
        chk("t1_data", data, 8'hA5);
        chk("t1_valid_held", valid, 1);
        pulse_ack();
        chk("t1_valid_after_ack", valid, 0);

        // Short start glitch
        fe0 = fe_cnt; ov0 = ov_cnt;
        drive_bit(1'b0, 3);
        rx = 1'b1;
        wait_busy(1'b1, 10, seen);
        chk("t2_busy_rise", seen, 1);
        wait_busy(1'b0, 20, seen);
        chk("t2_busy_fall", seen, 1);
        settle();
        chk("t2_valid", valid, 0);
        chk("t2_frame_err", fe_cnt - fe0, 0);
        chk("t2_overrun", ov_cnt - ov0, 0);

        // Stop bit held low: one frame_err, line stays locked until it goes high
        fe0 = fe_cnt;
        send_body(8'h3C);
        drive_bit(1'b0, 30);
        chk("t3_busy_in_break", busy, 1);
        chk("t3_frame_err", fe_cnt - fe0, 1);
        drive_bit(1'b1, N);
        chk("t3_busy_released", busy, 0);
        chk("t3_valid", valid, 0);
        chk("t3_frame_err_once", fe_cnt - fe0, 1);

        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt; ov0 = ov_cnt;
            send_frame(vecs[i].b, vecs[i].stop_ok);
            settle();
            chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
            chk($sformatf("vec%0d_ov", i), ov_cnt - ov0, vecs[i].exp_ov);
            if (vecs[i].ack_after) begin
                pulse_ack();
                chk($sformatf("vec%0d_acked", i), valid, 0);
            end
        end

        // Back-to-back frames without ack, then ack coinciding with delivery
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        settle();
        chk("t4_data_first", data, 8'h11);
        chk("t4_valid", valid, 1);
        chk("t4_overrun", ov_cnt - ov0, 1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (c_lat) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        settle();
        chk("t4_data_swap", data, 8'h22);
        chk("t4_valid_swap", valid, 1);
        chk("t4_no_overrun", ov_cnt - ov0, 0);

        // Reset in the middle of a frame
        drive_bit(1'b0, N);
        drive_bit(1'b1, 4 * N);
        rst = 1'b0;
        #1;
        chk("t5_data", data, 8'h00);
        chk("t5_valid", valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_frame_err", frame_err, 0);
        chk("t5_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b1);
        settle();
        chk("t5_rx_after", data, 8'h5A);
        chk("t5_valid_after", valid, 1);
        mv = 1'b1;
        md = 8'h5A;

`ifdef UART_RX_PARITY_EN
        pulse_ack();
        pe0 = pe_cnt;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        settle();
        chk("t6_parity_err", pe_cnt - pe0, 1);
        chk("t6_bad_valid", valid, 0);
        pe0 = pe_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        settle();
        chk("t6_good_pe", pe_cnt - pe0, 0);
        chk("t6_good_data", data, 8'h07);
        chk("t6_good_valid", valid, 1);
        md = 8'h07;
`endif

        // Random frames against a frame-level model of the handshake
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                mv = 1'b0;
            end
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1;
            end
            rb        = 8'($urandom_range(0, 255));
            r_stop_ok = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            par_flip  = ($urandom_range(0, 3) == 0);
`endif
            e_fe = r_stop_ok ? 0 : 1;
            e_pe = par_flip ? 1 : 0;
            e_ov = 0;
            if (r_stop_ok && !par_flip) begin
                if (mv) begin
                    e_ov = 1;
                end else begin
                    mv = 1'b1;
                    md = rb;
                end
            end
            fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
            send_frame(rb, r_stop_ok);
            settle();
            chk($sformatf("rnd%0d_valid", it), valid, mv);
            if (mv) chk($sformatf("rnd%0d_data", it), data, md);
            chk($sformatf("rnd%0d_fe", it), fe_cnt - fe0, e_fe);
            chk($sformatf("rnd%0d_ov", it), ov_cnt - ov0, e_ov);
`ifdef UART_RX_PARITY_EN
            chk($sformatf("rnd%0d_pe", it), pe_cnt - pe0, e_pe);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
